// File: rtl/reg_writeback.sv
// Register-file writeback: buffers ALU results in a FIFO, gives load data priority,
// retires one write per clock and holds NZCV. Optional pending mask: REG_WB_PENDING_EN.
module reg_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_rd,
    input  logic        alu_wen,
    input  logic [31:0] alu_result,
    input  logic        alu_set_flags,
    input  logic [3:0]  alu_flags,
    input  logic        mem_valid,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic [31:0] write_reg,
    output logic [31:0] write_data,
    output logic        regwrite,
    output logic        negative_flag,
    output logic        zero_flag,
    output logic        carry_flag,
`ifdef REG_WB_PENDING_EN
    output logic        overflow_flag,
    output logic [15:0] pending
`else
    output logic        overflow_flag
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [3:0]  rd;
        logic        wen;
        logic [31:0] result;
        logic        set_flags;
        logic [3:0]  flags;
    } entry_t;

    entry_t          fifo [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      wr_idx;
    entry_t          head;
    logic            push;
    logic            pop;

    assign alu_ready = !reset && (count < CW'(DEPTH));
    assign push      = alu_valid && alu_ready;
    assign pop       = !mem_valid && (count != '0);
    assign head      = fifo[rd_ptr];
    assign write_reg = {28'd0, wr_idx};

    // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo[wr_ptr] <= '{rd: alu_rd, wen: alu_wen, result: alu_result,
                              set_flags: alu_set_flags, flags: alu_flags};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            regwrite      <= 1'b0;
            wr_idx        <= '0;
            write_data    <= '0;
            negative_flag <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Load data always wins; buffered ALU results wait behind it.
            if (mem_valid) begin
                regwrite   <= 1'b1;
                wr_idx     <= mem_rd;
                write_data <= mem_data;
            end else if (pop) begin
                regwrite   <= head.wen;
                wr_idx     <= head.rd;
                write_data <= head.result;
                if (head.set_flags) begin
                    negative_flag <= head.flags[3];
                    zero_flag     <= head.flags[2];
                    carry_flag    <= head.flags[1];
                    overflow_flag <= head.flags[0];
                end
            end else begin
                regwrite <= 1'b0;
            end
        end
    end

`ifdef REG_WB_PENDING_EN
    // Mark every register targeted by an occupied slot that will write.
    always_comb begin
        logic [AW-1:0] off;
        pending = '0;
        off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if ((CW'(off) < count) && fifo[i].wen) begin
                pending[fifo[i].rd] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: scoreboard of expected ALU retirements plus
// a one-cycle model of load writes; build with REG_WB_PENDING_EN to also check pending.
module tb_reg_writeback;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [3:0]  alu_rd = '0;
    logic        alu_wen = 1'b0;
    logic [31:0] alu_result = '0;
    logic        alu_set_flags = 1'b0;
    logic [3:0]  alu_flags = '0;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic [31:0] write_reg;
    logic [31:0] write_data;
    logic        regwrite;
    logic        negative_flag, zero_flag, carry_flag, overflow_flag;
`ifdef REG_WB_PENDING_EN
    logic [15:0] pending;
`endif

    reg_writeback #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_wen(alu_wen), .alu_result(alu_result),
        .alu_set_flags(alu_set_flags), .alu_flags(alu_flags),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
        .negative_flag(negative_flag), .zero_flag(zero_flag),
        .carry_flag(carry_flag),
`ifdef REG_WB_PENDING_EN
        .overflow_flag(overflow_flag),
        .pending(pending)
`else
        .overflow_flag(overflow_flag)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  exp_flags = '0;
    int          errors = 0;
    int          checks = 0;

    logic        rst_was = 1'b1;
    logic        mem_was = 1'b0;
    logic [3:0]  mem_rd_was = '0;
    logic [31:0] mem_data_was = '0;

    function automatic logic [3:0] flags_now();
        return {negative_flag, zero_flag, carry_flag, overflow_flag};
    endfunction

    // Reference model of what the previous edge should have produced.
    always @(posedge clock) begin
        rst_was      = reset;
        mem_was      = mem_valid;
        mem_rd_was   = mem_rd;
        mem_data_was = mem_data;
    end

    always @(negedge clock) begin
        exp_t e;
        if (rst_was) begin
            checks++;
            if (regwrite !== 1'b0) begin
                errors++;
                $display("FAIL reset_strobe: regwrite=%b required 0 at %0t", regwrite, $time);
            end
        end else if (mem_was) begin
            checks++;
            if (regwrite !== 1'b1 || write_reg !== {28'd0, mem_rd_was} || write_data !== mem_data_was) begin
                errors++;
                $display("FAIL mem_write: got we=%b r%0d %h required we=1 r%0d %h at %0t",
                         regwrite, write_reg, write_data, mem_rd_was, mem_data_was, $time);
            end
        end else if (regwrite === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: r%0d %h with nothing expected at %0t",
                         write_reg, write_data, $time);
            end else begin
                e = sb.pop_front();
                if (write_reg !== {28'd0, e.rd} || write_data !== e.data || flags_now() !== e.flags) begin
                    errors++;
                    $display("FAIL alu_retire: got r%0d %h nzcv=%b required r%0d %h nzcv=%b at %0t",
                             write_reg, write_data, flags_now(), e.rd, e.data, e.flags, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_alu(input logic [3:0] rd, input logic wen, input logic [31:0] d,
                            input logic sf, input logic [3:0] fl);
        int n = 0;
        alu_valid = 1'b1; alu_rd = rd; alu_wen = wen; alu_result = d;
        alu_set_flags = sf; alu_flags = fl;
        while (!alu_ready && n < 50) begin
            step();
            n++;
        end
        if (!alu_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: alu_ready=%b required 1", alu_ready);
        end
        step();
        alu_valid = 1'b0;
        if (sf) exp_flags = fl;
        if (wen) sb.push_back('{rd, d, exp_flags});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            step();
            n++;
        end
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes never retired, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++; $display("FAIL ready_in_reset: got %b required 0", alu_ready);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b0 || write_reg !== 32'd0 || write_data !== 32'd0 || flags_now() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: we=%b r=%h d=%h nzcv=%b required 0/0/0/0000",
                     regwrite, write_reg, write_data, flags_now());
        end
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b required 1", alu_ready);
        end
        step();
    endtask

    task automatic test_single_alu();
        push_alu(4'd2, 1'b1, 32'h12345678, 1'b0, 4'b0000);
        checks++;
        if (regwrite !== 1'b0) begin
            errors++; $display("FAIL alu_latency_early: regwrite=%b required 0", regwrite);
        end
        step();
        checks++;
        if (regwrite !== 1'b1 || write_reg !== 32'd2 || write_data !== 32'h12345678 || flags_now() !== 4'b0000) begin
            errors++;
            $display("FAIL single_alu: we=%b r%0d %h nzcv=%b required 1 r2 12345678 0000",
                     regwrite, write_reg, write_data, flags_now());
        end
        drain();
    endtask

    task automatic test_compare();
        push_alu(4'd7, 1'b0, 32'h0, 1'b1, 4'b0100);
        step();
        checks++;
        if (zero_flag !== 1'b1 || flags_now() !== 4'b0100 || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL compare: nzcv=%b we=%b required 0100 0", flags_now(), regwrite);
        end
        push_alu(4'd0, 1'b1, 32'hABCDEF01, 1'b0, 4'b1011);
        drain();
        checks++;
        if (zero_flag !== 1'b1) begin
            errors++; $display("FAIL flag_hold: Z=%b required 1", zero_flag);
        end
        // Entry with neither write nor flag update must be invisible.
        push_alu(4'd9, 1'b0, 32'hFFFFFFFF, 1'b0, 4'b1111);
        step();
        checks++;
        if (regwrite !== 1'b0 || flags_now() !== 4'b0100) begin
            errors++; $display("FAIL nop_entry: we=%b nzcv=%b required 0 0100", regwrite, flags_now());
        end
    endtask

    task automatic test_mem_priority();
        mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 32'hDEADBEEF;
        push_alu(4'd3, 1'b1, 32'h00000333, 1'b1, 4'b1001);
        mem_valid = 1'b0;
        checks++;
        if (regwrite !== 1'b1 || write_reg !== 32'd5 || write_data !== 32'hDEADBEEF || flags_now() !== 4'b0100) begin
            errors++;
            $display("FAIL mem_first: we=%b r%0d %h nzcv=%b required 1 r5 deadbeef 0100",
                     regwrite, write_reg, write_data, flags_now());
        end
        step();
        checks++;
        if (regwrite !== 1'b1 || write_reg !== 32'd3 || flags_now() !== 4'b1001) begin
            errors++;
            $display("FAIL alu_second: we=%b r%0d nzcv=%b required 1 r3 1001", regwrite, write_reg, flags_now());
        end
        drain();
    endtask

    task automatic test_back_to_back();
        mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rd = 4'(8 + i); mem_data = $urandom;
            checks++;
            if (alu_ready !== 1'b1) begin
                errors++; $display("FAIL ready_fill%0d: got %b required 1", i, alu_ready);
            end
            push_alu(4'(i + 1), 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 4'b0000);
        end
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++; $display("FAIL ready_full: got %b required 0", alu_ready);
        end
        // Offer a fifth op while full; it must not be taken.
        alu_valid = 1'b1; alu_rd = 4'd15; alu_wen = 1'b1; alu_result = 32'hBAD0BAD0;
        mem_rd = 4'd12; mem_data = 32'h0C0C0C0C;
        step();
        alu_valid = 1'b0;
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++; $display("FAIL ready_still_full: got %b required 0", alu_ready);
        end
        mem_valid = 1'b0;
        drain();
        for (int i = 0; i < 4; i++) begin
            push_alu(4'(10 + i), 1'b1, $urandom, 1'(i[0]), 4'(i * 3));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1;
        mem_rd = 4'd1; mem_data = 32'h11111111;
        push_alu(4'd4, 1'b1, 32'h4, 1'b0, 4'b0);
        push_alu(4'd6, 1'b1, 32'h6, 1'b0, 4'b0);
        push_alu(4'd4, 1'b0, 32'h7, 1'b1, 4'b1111);
`ifdef REG_WB_PENDING_EN
        checks++;
        if (pending !== 16'h0050) begin
            errors++; $display("FAIL pending_mask: got %h required 0050", pending);
        end
`endif
        mem_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        exp_flags = '0;
`ifdef REG_WB_PENDING_EN
        checks++;
        if (pending !== 16'h0000) begin
            errors++; $display("FAIL pending_reset: got %h required 0000", pending);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (regwrite !== 1'b0 || flags_now() !== 4'b0000) begin
                errors++;
                $display("FAIL after_reset%0d: we=%b nzcv=%b required 0 0000", i, regwrite, flags_now());
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_compare();
        test_mem_priority();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback unit that drives the register-file write port and CPSR flag inputs of `registers`. It accepts completed results from the ALU (buffered in a small FIFO with valid/ready handshake) and from the load/store path (unbuffered, highest priority). It retires at most one register write per clock and holds the NZCV flag outputs stable between flag-setting operations, because `registers` samples the flags every cycle.

## Interface
Parameters:
- `DEPTH`, 4: ALU result FIFO entries; power of two, 2..16.

Ports:
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high.
- `alu_valid`  input  1  ALU result offered.
- `alu_ready`  output  1  FIFO can accept; `!reset && count < DEPTH` (combinational).
- `alu_rd`  input  4  destination register 0..15.
- `alu_wen`  input  1  result writes `alu_rd`.
- `alu_result`  input  32  result data.
- `alu_set_flags`  input  1  update NZCV from `alu_flags`.
- `alu_flags`  input  4  {N,Z,C,V}.
- `mem_valid`  input  1  load data returning; always accepted, never stalls.
- `mem_rd`  input  4  load destination.
- `mem_data`  input  32  load data.
- `write_reg`  output  32  register-file write index; bits [31:4] always 0.
- `write_data`  output  32  register-file write data.
- `regwrite`  output  1  write strobe, one cycle per retired write.
- `negative_flag`, `zero_flag`, `carry_flag`, `overflow_flag`  output  1 each  held CPSR flags.
- `pending`  output  16  per-register outstanding-write mask (only with `REG_WB_PENDING_EN`).

## Operation
- ALU handshake: entry enqueued on edge where `alu_valid && alu_ready`; fields `{rd,wen,result,set_flags,flags}` stored together.
- Selection each cycle: `mem_valid` wins; otherwise FIFO head if nonempty; otherwise idle.
- Mem selected: `write_reg<=mem_rd`, `write_data<=mem_data`, `regwrite<=1`; flags unchanged; FIFO not popped.
- FIFO head selected: popped; `regwrite<=wen`; `write_reg/write_data` loaded from entry; if `set_flags`, the four flag outputs load `flags` on the same edge; otherwise flags hold.
- Entry with `wen=0, set_flags=1` (compare): flags update, `regwrite=0`. Entry with both 0: consumes one pop cycle, no visible effect.
- Idle: `regwrite<=0`; `write_reg`, `write_data`, flags hold last values.
- Push and pop on the same edge allowed; count unchanged. When full, `alu_ready=0` even if a pop occurs that edge (no pass-through).
- Read/write pointers wrap modulo `DEPTH`; count width `$clog2(DEPTH)+1`.
- Ordering: ALU results retire in acceptance order; mem writes may overtake buffered ALU writes (the issue stage guarantees no WAW between them).

## Timing
- Reset (edge with `reset=1`): FIFO empty, pointers 0, `regwrite=0`, `write_reg=0`, `write_data=0`, all flags 0, `pending=0`. `alu_ready=0` while reset is high. Reset mid-operation discards all buffered entries and any in-flight write; no strobe is issued on or after that edge.
- Mem latency: `mem_valid` on edge t, so `regwrite=1` in the cycle after t.
- ALU latency with FIFO empty and no mem: accepted at edge t, retired at edge t+1; `regwrite` high the cycle after t+1.
- Sustained mem traffic starves the FIFO; `alu_ready` drops once `count==DEPTH`.
- All outputs except `alu_ready` and `pending` are registered.

## Configuration
- `REG_WB_PENDING_EN` defined: `pending[r]=1` iff a FIFO entry with `wen=1` targets r (combinational over valid entries); it clears on the pop edge. The issue stage uses this for RAW interlock.
- Not defined: the `pending` port is absent, and no per-entry compare logic is built.

## Test plan
- Reset then idle: after reset, `regwrite=0`, `write_reg=0`, flags 0000, `alu_ready=1`.
- Single ALU op: rd=2, data 0x12345678, wen=1, set_flags=0 at edge t produces `regwrite=1`, `write_reg=2`, `write_data=0x12345678` in the cycle after t+1; flags stay 0000.
- Flag-only compare: wen=0, set_flags=1, flags 0100 produces Z=1 and `regwrite=0`. A later wen=1, set_flags=0 write to r0 of 0xABCDEF01 leaves Z=1.
- Mem priority: ALU rd=3 and mem rd=5 (0xDEADBEEF) on the same edge. r5 retires first, r3 retires the next cycle.
- Backpressure and wrap: hold `mem_valid=1` while pushing 4 ALU ops, so `alu_ready=0` on the 5th. Release mem; the 4 ops retire in order. Push 4 more and verify pointer wrap and order.
- Reset mid-stream: with 3 entries queued, assert reset for one edge. No further `regwrite` is issued, and `pending=0`.
